// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, arbiter state encodings
// and default bus widths for the arbiter and its pad register stage.
package sdram_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int BA_W_DEF   = 2;
  localparam int DQ_W_DEF   = 16;

  // Commands are {cs_n, ras_n, cas_n, we_n}.
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  typedef enum logic [4:0] {
    ST_INIT  = 5'b00001,
    ST_ARBIT = 5'b00010,
    ST_AREF  = 5'b00100,
    ST_WRITE = 5'b01000,
    ST_READ  = 5'b10000
  } arb_state_e;

endpackage

// File: rtl/sdram_pin_reg.sv
// Registered SDRAM pad stage: one flop layer between the arbiter mux and
// the pins so every pin changes exactly one cycle after its source.
module sdram_pin_reg
  import sdram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BA_W   = BA_W_DEF,
  parameter int DQ_W   = DQ_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        cmd_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [BA_W-1:0]   bank_in,
  input  logic [DQ_W-1:0]   dq_in,
  input  logic              oe_in,
  output logic              cke,
  output logic              cs_n,
  output logic              ras_n,
  output logic              cas_n,
  output logic              we_n,
  output logic [BA_W-1:0]   bank,
  output logic [ADDR_W-1:0] addr,
  output logic [DQ_W-1:0]   dq_out,
  output logic              dq_oe
);

  logic [3:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BA_W-1:0]   bank_q, bank_d;
  logic [DQ_W-1:0]   dq_q, dq_d;
  logic              oe_q, oe_d;
  logic              cke_q, cke_d;

  always_comb begin
    cmd_d  = cmd_in;
    addr_d = addr_in;
    bank_d = bank_in;
    dq_d   = dq_in;
    oe_d   = oe_in;
    // Clock enable rises on the first edge out of reset and then holds.
    cke_d  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q  <= CMD_NOP;
      addr_q <= '0;
      bank_q <= '0;
      dq_q   <= '0;
      oe_q   <= 1'b0;
      cke_q  <= 1'b0;
    end else begin
      cmd_q  <= cmd_d;
      addr_q <= addr_d;
      bank_q <= bank_d;
      dq_q   <= dq_d;
      oe_q   <= oe_d;
      cke_q  <= cke_d;
    end
  end

  assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
  assign addr   = addr_q;
  assign bank   = bank_q;
  assign dq_out = dq_q;
  assign dq_oe  = oe_q;
  assign cke    = cke_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Grants the SDRAM bus to one engine at a time (refresh > write > read after
// init) and muxes the owner's command/address/data onto registered pins.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BA_W   = BA_W_DEF,
  parameter int DQ_W   = DQ_W_DEF
) (
  input  logic              sclk,
  input  logic              reset,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              ref_req,
  output logic              ref_en,
  input  logic              ref_end,
  input  logic [3:0]        ref_cmd,
  input  logic [ADDR_W-1:0] ref_addr,
  input  logic              wr_req,
  output logic              wr_en,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BA_W-1:0]   wr_bank,
  input  logic [DQ_W-1:0]   wr_data,
  input  logic              rd_req,
  output logic              rd_en,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BA_W-1:0]   rd_bank,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_bank,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DQ_W-1:0]   sdram_dq_out,
  output logic              sdram_dq_oe,
  output logic [4:0]        dbg_state
);

  arb_state_e state_q, state_d;

  // Every grant returns through ARBIT, which guarantees a one-cycle gap
  // and lets a refresh that arrived mid-burst win the next arbitration.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (init_end) state_d = ST_ARBIT;
      ST_ARBIT: begin
        if (ref_req)     state_d = ST_AREF;
        else if (wr_req) state_d = ST_WRITE;
        else if (rd_req) state_d = ST_READ;
      end
      ST_AREF:  if (ref_end) state_d = ST_ARBIT;
      ST_WRITE: if (wr_end)  state_d = ST_ARBIT;
      ST_READ:  if (rd_end)  state_d = ST_ARBIT;
      default:  state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  assign ref_en    = (state_q == ST_AREF);
  assign wr_en     = (state_q == ST_WRITE);
  assign rd_en     = (state_q == ST_READ);
  assign dbg_state = state_q;

  logic [3:0]        mux_cmd;
  logic [ADDR_W-1:0] mux_addr;
  logic [BA_W-1:0]   mux_bank;
  logic [DQ_W-1:0]   mux_dq;
  logic              mux_oe;

  // Init and refresh have no bank port, so they drive bank 0.
  always_comb begin
    mux_cmd  = CMD_NOP;
    mux_addr = '0;
    mux_bank = '0;
    mux_dq   = '0;
    mux_oe   = 1'b0;
    case (state_q)
      ST_INIT: begin
        mux_cmd  = init_cmd;
        mux_addr = init_addr;
      end
      ST_AREF: begin
        mux_cmd  = ref_cmd;
        mux_addr = ref_addr;
      end
      ST_WRITE: begin
        mux_cmd  = wr_cmd;
        mux_addr = wr_addr;
        mux_bank = wr_bank;
        mux_dq   = wr_data;
        mux_oe   = 1'b1;
      end
      ST_READ: begin
        mux_cmd  = rd_cmd;
        mux_addr = rd_addr;
        mux_bank = rd_bank;
      end
      default: begin
        mux_cmd  = CMD_NOP;
      end
    endcase
  end

  sdram_pin_reg #(
    .ADDR_W (ADDR_W),
    .BA_W   (BA_W),
    .DQ_W   (DQ_W)
  ) u_pin_reg (
    .clk     (sclk),
    .rst_n   (reset),
    .cmd_in  (mux_cmd),
    .addr_in (mux_addr),
    .bank_in (mux_bank),
    .dq_in   (mux_dq),
    .oe_in   (mux_oe),
    .cke     (sdram_cke),
    .cs_n    (sdram_cs_n),
    .ras_n   (sdram_ras_n),
    .cas_n   (sdram_cas_n),
    .we_n    (sdram_we_n),
    .bank    (sdram_bank),
    .addr    (sdram_addr),
    .dq_out  (sdram_dq_out),
    .dq_oe   (sdram_dq_oe)
  );

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Downstream consumer of the SDRAM init, auto-refresh, write and read engines.
Grants exactly one engine at a time, using the priorities below, and returns to arbitration on that engine's end pulse.
Muxes the granted engine's command, address, bank and write data onto one registered SDRAM pin interface.
Sits between the engines and the top-level SDRAM pads.

Parameters:
ADDR_W, 13, SDRAM row/column address width
BA_W, 2, bank address width
DQ_W, 16, data bus width

Ports:
sclk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
init_end  in  1  level; init sequence complete
init_cmd  in  4  {cs_n,ras_n,cas_n,we_n} from init engine
init_addr  in  ADDR_W  init address (mode register value)
ref_req  in  1  refresh request, level
ref_en  out  1  refresh grant
ref_end  in  1  1-cycle pulse; refresh done
ref_cmd  in  4  refresh engine command
ref_addr  in  ADDR_W  refresh engine address
wr_req  in  1  write request, level
wr_en  out  1  write grant
wr_end  in  1  1-cycle pulse; write engine released bus
wr_cmd  in  4  write engine command
wr_addr  in  ADDR_W  write engine address
wr_bank  in  BA_W  write engine bank
wr_data  in  DQ_W  write data
rd_req  in  1  read request, level
rd_en  out  1  read grant
rd_end  in  1  1-cycle pulse; read engine released bus
rd_cmd  in  4  read engine command
rd_addr  in  ADDR_W  read engine address
rd_bank  in  BA_W  read engine bank
sdram_cke  out  1  clock enable
sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins
sdram_bank  out  BA_W  bank pins
sdram_addr  out  ADDR_W  address pins
sdram_dq_out  out  DQ_W  write data to pad
sdram_dq_oe  out  1  pad output enable

Behaviour:
- Reset is asynchronous, active-low, and applies to every register.
- Reset values: state INIT, all *_en 0, command pins NOP (0111), sdram_addr 0, sdram_bank 0, sdram_dq_out 0, sdram_dq_oe 0, sdram_cke 0.
- sdram_cke goes to 1 on the first sclk edge after reset deasserts and stays 1.
- States (one-hot, 5 bits):
  - INIT: stays until init_end=1, then goes to ARBIT.
  - ARBIT: priority ref_req > wr_req > rd_req; goes to AREF, WRITE or READ respectively. If no request, stays in ARBIT.
  - AREF: leaves to ARBIT on ref_end.
  - WRITE: leaves to ARBIT on wr_end.
  - READ: leaves to ARBIT on rd_end.
- Grants: ref_en = (state==AREF), wr_en = (state==WRITE), rd_en = (state==READ). Grants are decoded from the state register, so they are glitch-free.
- A grant rises in the cycle after ARBIT sees the request.
- A grant falls in the cycle after the end pulse.
- Minimum of 1 ARBIT cycle between consecutive grants.
- No preemption: refresh arriving during WRITE or READ waits. The engines abort their own bursts on ref_req and pulse *_end; the following ARBIT then picks refresh.
- End pulses seen outside the matching state are ignored.
- A request held while another engine owns the bus is served at the next ARBIT; no request is lost.
- Output mux: source selected by current state. INIT uses init_*, AREF uses ref_*, WRITE uses wr_*, READ uses rd_*, ARBIT drives NOP/addr 0/bank 0.
- init and ref supply no bank port; bank is 0 for them.
- Mux result is registered: pins reflect the source's inputs with exactly 1 cycle of latency.
- sdram_dq_out registers wr_data every cycle while in WRITE, else 0.
- sdram_dq_oe = registered (state==WRITE && wr_cmd==WRITE 0100 or burst in flight). Simplified rule: oe=1 for each cycle registered in WRITE, 0 otherwise.
- Illegal state encoding recovers to INIT on the next edge.
- Reset mid-operation: all grants drop immediately and the state returns to INIT. init_end must be seen again before any grant.

Decomposition:
- Shared package sdram_pkg holds:
  - command constants CMD_NOP 0111, CMD_PRE 0010, CMD_AREF 0001, CMD_ACT 0011, CMD_WR 0100, CMD_RD 0101, CMD_MRS 0000;
  - the arbiter state encodings;
  - ADDR_W, BA_W, DQ_W defaults.
- One sub-module is natural: sdram_pin_reg, the registered pad stage for cmd/addr/bank/dq/oe/cke.

Test Plan:
- Reset, hold init_end=0 for 10 cycles, init_cmd=0010 -> pins show 0010 1 cycle later, no grants. Set init_end=1 -> ARBIT, pins NOP.
- wr_req=1 alone -> wr_en=1 the next cycle. wr_cmd=0100, wr_addr=0x004, wr_data=0x0001 -> pins 0100/0x004, dq_out 0x0001, oe=1 one cycle later. wr_end pulse -> wr_en=0 the next cycle.
- ref_req, wr_req and rd_req rise in the same ARBIT cycle -> ref_en first. After ref_end, wr_en. After wr_end, rd_en. Never two grants high at once.
- ref_req rises mid-WRITE -> wr_en held until wr_end, ARBIT for 1 cycle, then ref_en=1.
- Spurious rd_end pulse during WRITE -> ignored, wr_en stays 1.
- reset low mid-WRITE -> wr_en, oe and cke all 0 asynchronously. After release, no grant until init_end=1.
